// File: rtl/cmd_dispatch.sv
// cmd_dispatch: command sequencer between the comm wrapper and the flight datapath.
// Decodes received frames, updates the attitude/thrust setpoints, runs the battery
// conversion and inertial calibration handshakes, answers every command with one
// response byte, and owns the comm-loss watchdog and motor-off control.
// Pulse outputs and the response byte are precomputed one edge early so that they
// come straight from flops while still meeting the command-to-response latency.
module cmd_dispatch #(
   parameter int         WD_WIDTH   = 26,
   parameter int         SPIN_WIDTH = 25,
   parameter logic [7:0] ACK        = 8'hA5,
   parameter logic [7:0] NAK        = 8'hEE
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        cmd_rdy,
   input  logic [7:0]  cmd,
   input  logic [15:0] data,
   output logic        clr_cmd_rdy,
   output logic [7:0]  resp,
   output logic        send_resp,
   input  logic        resp_sent,
   output logic [15:0] d_ptch,
   output logic [15:0] d_roll,
   output logic [15:0] d_yaw,
   output logic [8:0]  thrst,
   output logic        strt_cnv,
   input  logic        cnv_cmplt,
   input  logic [11:0] batt,
   output logic        inertial_cal,
   output logic        strt_cal,
   input  logic        cal_done,
   output logic        motors_off
);

   localparam logic [7:0] CMD_REQ_BATT  = 8'h01;
   localparam logic [7:0] CMD_SET_PTCH  = 8'h02;
   localparam logic [7:0] CMD_SET_ROLL  = 8'h03;
   localparam logic [7:0] CMD_SET_YAW   = 8'h04;
   localparam logic [7:0] CMD_SET_THRST = 8'h05;
   localparam logic [7:0] CMD_CALIBRATE = 8'h06;
   localparam logic [7:0] CMD_EMER_LAND = 8'h07;
   localparam logic [7:0] CMD_MTRS_OFF  = 8'h08;

   localparam logic [WD_WIDTH-1:0]   WD_MAX    = {WD_WIDTH{1'b1}};
   localparam logic [WD_WIDTH-1:0]   WD_ZERO   = {WD_WIDTH{1'b0}};
   localparam logic [WD_WIDTH-1:0]   WD_ONE    = {{(WD_WIDTH-1){1'b0}}, 1'b1};
   localparam logic [SPIN_WIDTH-1:0] SPIN_ZERO = {SPIN_WIDTH{1'b0}};
   localparam logic [SPIN_WIDTH-1:0] SPIN_ONE  = {{(SPIN_WIDTH-1){1'b0}}, 1'b1};
   // Value one below all-ones: seeing it means the counter hits all-ones next edge.
   localparam logic [SPIN_WIDTH-1:0] SPIN_LAST = {{(SPIN_WIDTH-1){1'b1}}, 1'b0};

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      DISPATCH  = 3'd1,
      WAIT_CNV  = 3'd2,
      SPIN      = 3'd3,
      WAIT_CAL  = 3'd4,
      WAIT_SENT = 3'd5
   } state_t;

   state_t                state_r, state_nxt_s;
   logic [7:0]            cmd_r, cmd_nxt_s;
   logic [15:0]           data_r, data_nxt_s;
   logic [WD_WIDTH-1:0]   wd_r, wd_nxt_s, wd_inc_s;
   logic [SPIN_WIDTH-1:0] spin_r, spin_nxt_s;
   logic [15:0]           d_ptch_r, d_ptch_nxt_s;
   logic [15:0]           d_roll_r, d_roll_nxt_s;
   logic [15:0]           d_yaw_r, d_yaw_nxt_s;
   logic [8:0]            thrst_r, thrst_nxt_s;
   logic [7:0]            resp_r, resp_nxt_s;
   logic                  send_resp_r, send_resp_nxt_s;
   logic                  strt_cnv_r, strt_cnv_nxt_s;
   logic                  strt_cal_r, strt_cal_nxt_s;
   logic                  motors_off_r, motors_off_nxt_s;
   logic                  inertial_cal_r, inertial_cal_nxt_s;
   logic                  clr_cmd_rdy_s;
   logic                  accept_s;
   logic                  wd_timeout_s;

   assign clr_cmd_rdy  = clr_cmd_rdy_s;
   assign resp         = resp_r;
   assign send_resp    = send_resp_r;
   assign d_ptch       = d_ptch_r;
   assign d_roll       = d_roll_r;
   assign d_yaw        = d_yaw_r;
   assign thrst        = thrst_r;
   assign strt_cnv     = strt_cnv_r;
   assign strt_cal     = strt_cal_r;
   assign motors_off   = motors_off_r;
   assign inertial_cal = inertial_cal_r;

   // Next-state, frame acceptance, watchdog and setpoint update logic.
   always_comb begin
      state_nxt_s        = state_r;
      cmd_nxt_s          = cmd_r;
      data_nxt_s         = data_r;
      spin_nxt_s         = spin_r;
      d_ptch_nxt_s       = d_ptch_r;
      d_roll_nxt_s       = d_roll_r;
      d_yaw_nxt_s        = d_yaw_r;
      thrst_nxt_s        = thrst_r;
      resp_nxt_s         = resp_r;
      send_resp_nxt_s    = 1'b0;
      strt_cnv_nxt_s     = 1'b0;
      strt_cal_nxt_s     = 1'b0;
      motors_off_nxt_s   = motors_off_r;
      inertial_cal_nxt_s = inertial_cal_r;
      clr_cmd_rdy_s      = 1'b0;

      accept_s = (state_r == IDLE) && cmd_rdy;

      // Watchdog saturates at all-ones; an accepted frame restarts it.
      if (wd_r == WD_MAX) begin
         wd_inc_s = wd_r;
      end else begin
         wd_inc_s = wd_r + WD_ONE;
      end
      if (accept_s) begin
         wd_nxt_s = WD_ZERO;
      end else begin
         wd_nxt_s = wd_inc_s;
      end
      wd_timeout_s = (wd_nxt_s == WD_MAX);

      // Comm loss: keep the setpoints at zero for as long as the watchdog is saturated.
      if (wd_timeout_s) begin
         d_ptch_nxt_s = 16'h0000;
         d_roll_nxt_s = 16'h0000;
         d_yaw_nxt_s  = 16'h0000;
         thrst_nxt_s  = 9'h000;
      end else begin
         d_ptch_nxt_s = d_ptch_r;
      end

      case (state_r)
         IDLE: begin
            if (cmd_rdy) begin
               clr_cmd_rdy_s = 1'b1;
               cmd_nxt_s     = cmd;
               data_nxt_s    = data;
               state_nxt_s   = DISPATCH;
               // Decode early so resp/send_resp are already registered during DISPATCH.
               case (cmd)
                  CMD_REQ_BATT: begin
                     strt_cnv_nxt_s = 1'b1;
                  end
                  CMD_CALIBRATE: begin
                     strt_cnv_nxt_s = 1'b0;
                  end
                  CMD_SET_PTCH, CMD_SET_ROLL, CMD_SET_YAW, CMD_SET_THRST,
                  CMD_EMER_LAND, CMD_MTRS_OFF: begin
                     resp_nxt_s      = ACK;
                     send_resp_nxt_s = 1'b1;
                  end
                  default: begin
                     resp_nxt_s      = NAK;
                     send_resp_nxt_s = 1'b1;
                  end
               endcase
            end else begin
               state_nxt_s = IDLE;
            end
         end
         DISPATCH: begin
            state_nxt_s = WAIT_SENT;
            case (cmd_r)
               CMD_SET_PTCH:  d_ptch_nxt_s = data_r;
               CMD_SET_ROLL:  d_roll_nxt_s = data_r;
               CMD_SET_YAW:   d_yaw_nxt_s  = data_r;
               CMD_SET_THRST: thrst_nxt_s  = data_r[8:0];
               CMD_EMER_LAND: begin
                  d_ptch_nxt_s = 16'h0000;
                  d_roll_nxt_s = 16'h0000;
                  d_yaw_nxt_s  = 16'h0000;
                  thrst_nxt_s  = 9'h000;
               end
               CMD_MTRS_OFF: motors_off_nxt_s = 1'b1;
               CMD_REQ_BATT: state_nxt_s = WAIT_CNV;
               CMD_CALIBRATE: begin
                  motors_off_nxt_s   = 1'b0;
                  inertial_cal_nxt_s = 1'b1;
                  spin_nxt_s         = SPIN_ZERO;
                  state_nxt_s        = SPIN;
               end
               default: state_nxt_s = WAIT_SENT;
            endcase
         end
         WAIT_CNV: begin
            if (cnv_cmplt) begin
               resp_nxt_s      = batt[11:4];
               send_resp_nxt_s = 1'b1;
               state_nxt_s     = WAIT_SENT;
            end else begin
               state_nxt_s = WAIT_CNV;
            end
         end
         SPIN: begin
            spin_nxt_s = spin_r + SPIN_ONE;
            // strt_cal rises in the same cycle the counter reads all-ones.
            if (spin_r == SPIN_LAST) begin
               strt_cal_nxt_s = 1'b1;
               state_nxt_s    = WAIT_CAL;
            end else begin
               state_nxt_s = SPIN;
            end
         end
         WAIT_CAL: begin
            if (cal_done) begin
               inertial_cal_nxt_s = 1'b0;
               resp_nxt_s         = ACK;
               send_resp_nxt_s    = 1'b1;
               state_nxt_s        = WAIT_SENT;
            end else begin
               state_nxt_s = WAIT_CAL;
            end
         end
         WAIT_SENT: begin
            if (resp_sent) begin
               state_nxt_s = IDLE;
            end else begin
               state_nxt_s = WAIT_SENT;
            end
         end
         default: begin
            state_nxt_s = IDLE;
         end
      endcase
   end

   // State, counters, setpoints and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r        <= IDLE;
         cmd_r          <= 8'h00;
         data_r         <= 16'h0000;
         wd_r           <= WD_ZERO;
         spin_r         <= SPIN_ZERO;
         d_ptch_r       <= 16'h0000;
         d_roll_r       <= 16'h0000;
         d_yaw_r        <= 16'h0000;
         thrst_r        <= 9'h000;
         resp_r         <= 8'h00;
         send_resp_r    <= 1'b0;
         strt_cnv_r     <= 1'b0;
         strt_cal_r     <= 1'b0;
         motors_off_r   <= 1'b1;
         inertial_cal_r <= 1'b0;
      end else begin
         state_r        <= state_nxt_s;
         cmd_r          <= cmd_nxt_s;
         data_r         <= data_nxt_s;
         wd_r           <= wd_nxt_s;
         spin_r         <= spin_nxt_s;
         d_ptch_r       <= d_ptch_nxt_s;
         d_roll_r       <= d_roll_nxt_s;
         d_yaw_r        <= d_yaw_nxt_s;
         thrst_r        <= thrst_nxt_s;
         resp_r         <= resp_nxt_s;
         send_resp_r    <= send_resp_nxt_s;
         strt_cnv_r     <= strt_cnv_nxt_s;
         strt_cal_r     <= strt_cal_nxt_s;
         motors_off_r   <= motors_off_nxt_s;
         inertial_cal_r <= inertial_cal_nxt_s;
      end
   end

endmodule

// File: doc/cmd_dispatch.md
Name: cmd_dispatch

Overview:
- Command sequencer between the UART comm wrapper (cmd/data frames from the remote CommMaster) and the flight datapath.
- Decodes each received frame and updates the flight setpoint registers (pitch/roll/yaw/thrust).
- Sequences battery A2D conversions and the inertial calibration handshake, and returns a one-byte response per command.
- Owns the comm-loss watchdog and motor-off control.

Parameters:
- WD_WIDTH, 26, watchdog counter width; timeout = 2^WD_WIDTH-1 clocks with no accepted command.
- SPIN_WIDTH, 25, spin-up counter width; motors run 2^SPIN_WIDTH-1 clocks before calibration starts.
- ACK, 8'hA5, positive acknowledge byte.
- NAK, 8'hEE, unknown-command response byte.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- cmd_rdy  in  1  frame available from comm wrapper
- cmd  in  8  command byte
- data  in  16  command data
- clr_cmd_rdy  out  1  one-cycle pulse; frame consumed
- resp  out  8  response byte
- send_resp  out  1  one-cycle pulse; transmit resp
- resp_sent  in  1  response transmission complete
- d_ptch, d_roll, d_yaw  out  16 each  signed desired attitudes
- thrst  out  9  desired thrust
- strt_cnv  out  1  one-cycle pulse; start battery conversion
- cnv_cmplt  in  1  battery conversion done
- batt  in  12  battery reading
- inertial_cal  out  1  high during calibration sequence
- strt_cal  out  1  one-cycle pulse to flight control calibration
- cal_done  in  1  calibration complete
- motors_off  out  1  forces ESC outputs idle

Behaviour:
- Reset values:
  - d_ptch/d_roll/d_yaw/thrst = 0; resp = 0; motors_off = 1.
  - All pulses low; inertial_cal = 0; state = IDLE; watchdog and spin counters = 0.
  - Reset mid-operation aborts any sequence immediately.
- Command codes:
  - 01 REQ_BATT
  - 02 SET_PTCH
  - 03 SET_ROLL
  - 04 SET_YAW
  - 05 SET_THRST (data[8:0])
  - 06 CALIBRATE
  - 07 EMER_LAND
  - 08 MTRS_OFF
  - other = unknown.
- IDLE:
  - When cmd_rdy=1, assert clr_cmd_rdy (Mealy, same cycle).
  - Latch cmd/data, clear watchdog, go to DISPATCH.
- DISPATCH (1 cycle):
  - SET_*: write the setpoint register at end of cycle; resp=ACK; assert send_resp; go to WAIT_SENT.
  - EMER_LAND: zero all four setpoints; motors_off unchanged; ACK; go to WAIT_SENT.
  - MTRS_OFF: motors_off=1; ACK; go to WAIT_SENT.
  - REQ_BATT: assert strt_cnv; go to WAIT_CNV.
  - CALIBRATE: motors_off=0; inertial_cal=1; clear spin counter; go to SPIN.
  - unknown: resp=NAK; assert send_resp; go to WAIT_SENT.
- WAIT_CNV:
  - On cnv_cmplt: resp=batt[11:4]; assert send_resp; go to WAIT_SENT.
- SPIN:
  - Spin counter increments each clock.
  - At all-ones: assert strt_cal; go to WAIT_CAL.
- WAIT_CAL:
  - On cal_done: inertial_cal=0; resp=ACK; assert send_resp; go to WAIT_SENT.
- WAIT_SENT:
  - On resp_sent, go to IDLE.
- Busy behaviour:
  - cmd_rdy asserted outside IDLE is not consumed; it stays pending and is accepted on return to IDLE.
- Watchdog:
  - Free-running counter; cleared only on frame acceptance.
  - On reaching 2^WD_WIDTH-1, it saturates and zeroes all four setpoints every cycle while saturated. motors_off is unchanged.
  - Counter stays saturated until the next accepted frame.
  - In the same cycle, a SET write takes priority over the watchdog clear. This cannot occur in practice, because acceptance clears the counter.
- Setpoint writes:
  - d_ptch/d_roll/d_yaw take data[15:0] verbatim; thrst takes data[8:0].
- Response latency:
  - Simple commands: send_resp is asserted exactly 1 cycle after the clr_cmd_rdy cycle.

Test Plan:
- Reset, then cmd=02 data=16'hFF9C -> clr_cmd_rdy 1 cycle; next cycle d_ptch=16'hFF9C, resp=A5, send_resp pulse; returns to IDLE after resp_sent.
- cmd=05 data=16'hFFFF -> thrst=9'h1FF, ACK.
- cmd=01, model returns batt=12'hC80 on cnv_cmplt -> strt_cnv pulse once; resp=8'hC8, send_resp.
- cmd=06 with SPIN_WIDTH=4 -> motors_off=0 and inertial_cal=1; strt_cal exactly 15 clocks later; cal_done -> inertial_cal=0, ACK.
- Set thrst=100, then no commands with WD_WIDTH=6 -> after 63 clocks all setpoints=0. A second cmd_rdy during WAIT_CNV is held until IDLE.
- cmd=8'h3C -> resp=EE. Assert rst_n low during SPIN -> motors_off=1, inertial_cal=0, state IDLE asynchronously.
